// File: rtl/timer_controller.sv
// Mode sequencer for an MM:SS BCD countdown: button edge events drive set/run/pause/done.
// Events are registered one stage after the prev registers, so a press changes state two edges after the level rises.
module timer_controller #(
    parameter int TICK_DIV = 50000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_start,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic [2:0] state,
    output logic       running,
    output logic       done
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SET_MIN = 3'd1;
    localparam logic [2:0] S_SET_SEC = 3'd2;
    localparam logic [2:0] S_RUN     = 3'd3;
    localparam logic [2:0] S_PAUSE   = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    logic          prev_mode, prev_inc, prev_start;
    logic          ev_mode, ev_inc, ev_start;
    logic          go_start, go_mode, go_inc;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [2:0]    state_nxt;
    logic [3:0]    mt_nxt, mo_nxt, st_nxt, so_nxt;
    logic [3:0]    i_mt, i_mo, i_st, i_so;
    logic [3:0]    d_mt, d_mo, d_st, d_so;
    logic          tick, value_nz, dec_zero;

    // prev registers reset high so a button held through reset yields no event
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_mode  <= 1'b1;
            prev_inc   <= 1'b1;
            prev_start <= 1'b1;
            ev_mode    <= 1'b0;
            ev_inc     <= 1'b0;
            ev_start   <= 1'b0;
        end else begin
            prev_mode  <= btn_mode;
            prev_inc   <= btn_inc;
            prev_start <= btn_start;
            ev_mode    <= btn_mode & ~prev_mode;
            ev_inc     <= btn_inc & ~prev_inc;
            ev_start   <= btn_start & ~prev_start;
        end
    end

    assign go_start = ev_start;
    assign go_mode  = ev_mode & ~ev_start;
    assign go_inc   = ev_inc & ~ev_mode & ~ev_start;

    assign value_nz = |{min_tens, min_ones, sec_tens, sec_ones};
    assign tick     = (state == S_RUN) && (cnt == TICK_LAST);

    always_comb begin
        i_mt = min_tens;
        i_mo = min_ones + 4'd1;
        if (min_ones == 4'd9) begin
            i_mo = 4'd0;
            i_mt = (min_tens == 4'd9) ? 4'd0 : min_tens + 4'd1;
        end
        i_st = sec_tens;
        i_so = sec_ones + 4'd1;
        if (sec_ones == 4'd9) begin
            i_so = 4'd0;
            i_st = (sec_tens == 4'd5) ? 4'd0 : sec_tens + 4'd1;
        end
    end

    // one-second BCD borrow chain; only used while the value is nonzero
    always_comb begin
        d_mt = min_tens;
        d_mo = min_ones;
        d_st = sec_tens;
        d_so = sec_ones - 4'd1;
        if (sec_ones == 4'd0) begin
            d_so = 4'd9;
            d_st = sec_tens - 4'd1;
            if (sec_tens == 4'd0) begin
                d_st = 4'd5;
                d_mo = min_ones - 4'd1;
                if (min_ones == 4'd0) begin
                    d_mo = 4'd9;
                    d_mt = min_tens - 4'd1;
                end
            end
        end
    end

    assign dec_zero = ({d_mt, d_mo, d_st, d_so} == 16'h0000);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        mt_nxt    = min_tens;
        mo_nxt    = min_ones;
        st_nxt    = sec_tens;
        so_nxt    = sec_ones;
        case (state)
            S_IDLE: begin
                if (go_start) begin
                    if (value_nz) begin
                        state_nxt = S_RUN;
                        cnt_nxt   = '0;
                    end
                end else if (go_mode) begin
                    state_nxt = S_SET_MIN;
                end
            end
            S_SET_MIN: begin
                if (go_start) begin
                    if (value_nz) begin
                        state_nxt = S_RUN;
                        cnt_nxt   = '0;
                    end
                end else if (go_mode) begin
                    state_nxt = S_SET_SEC;
                end else if (go_inc) begin
                    mt_nxt = i_mt;
                    mo_nxt = i_mo;
                end
            end
            S_SET_SEC: begin
                if (go_start) begin
                    if (value_nz) begin
                        state_nxt = S_RUN;
                        cnt_nxt   = '0;
                    end
                end else if (go_mode) begin
                    state_nxt = S_IDLE;
                end else if (go_inc) begin
                    st_nxt = i_st;
                    so_nxt = i_so;
                end
            end
            S_RUN: begin
                cnt_nxt = tick ? '0 : cnt + 1'b1;
                if (go_start) begin
                    state_nxt = S_PAUSE;
                end else if (tick) begin
                    mt_nxt = d_mt;
                    mo_nxt = d_mo;
                    st_nxt = d_st;
                    so_nxt = d_so;
                    if (dec_zero) state_nxt = S_DONE;
                end
            end
            S_PAUSE: begin
                if (go_start) begin
                    state_nxt = S_RUN;
                end else if (go_mode) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end
            end
            S_DONE: begin
                if (ev_start | ev_mode | ev_inc) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            min_tens <= 4'd0;
            min_ones <= 4'd0;
            sec_tens <= 4'd0;
            sec_ones <= 4'd0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            min_tens <= mt_nxt;
            min_ones <= mo_nxt;
            sec_tens <= st_nxt;
            sec_ones <= so_nxt;
        end
    end

    assign running = (state == S_RUN);
    assign done    = (state == S_DONE);

endmodule

// File: tb/tb_timer_controller.sv
// Randomized and directed bench for timer_controller against a seconds-count reference model.
module tb_timer_controller;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_mode = 1'b0, btn_inc = 1'b0, btn_start = 1'b0;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic [2:0] state;
    logic       running, done;

    timer_controller #(.TICK_DIV(TD)) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_mode (btn_mode),
        .btn_inc  (btn_inc),
        .btn_start(btn_start),
        .min_tens (min_tens),
        .min_ones (min_ones),
        .sec_tens (sec_tens),
        .sec_ones (sec_ones),
        .state    (state),
        .running  (running),
        .done     (done)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    // reference model: value as whole minutes/seconds, events by sampled button history
    int         m_state, m_min, m_sec, m_cnt;
    logic [2:0] m_prev, m_evq;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [31:0] m_digits();
        return 32'((m_min / 10) * 4096 + (m_min % 10) * 256 + (m_sec / 10) * 16 + (m_sec % 10));
    endfunction

    function automatic logic [31:0] dut_digits();
        return {16'h0, min_tens, min_ones, sec_tens, sec_ones};
    endfunction

    task automatic model_reset();
        m_state = 0; m_min = 0; m_sec = 0; m_cnt = 0;
        m_prev = 3'b111; m_evq = 3'b000;
    endtask

    task automatic model_step();
        logic [2:0] b;
        logic s, md, in;
        int v;
        bit tk;
        b  = {btn_start, btn_mode, btn_inc};
        s  = m_evq[2];
        md = m_evq[1] && !s;
        in = m_evq[0] && !s && !md;
        v  = m_min * 60 + m_sec;
        case (m_state)
            0: if (s) begin
                   if (v != 0) begin m_state = 3; m_cnt = 0; end
               end else if (md) m_state = 1;
            1: if (s) begin
                   if (v != 0) begin m_state = 3; m_cnt = 0; end
               end else if (md) m_state = 2;
               else if (in) m_min = (m_min + 1) % 100;
            2: if (s) begin
                   if (v != 0) begin m_state = 3; m_cnt = 0; end
               end else if (md) m_state = 0;
               else if (in) m_sec = (m_sec + 1) % 60;
            3: begin
                   tk = (m_cnt == TD - 1);
                   m_cnt = (m_cnt + 1) % TD;
                   if (s) m_state = 4;
                   else if (tk) begin
                       v = v - 1;
                       m_min = v / 60;
                       m_sec = v % 60;
                       if (v == 0) m_state = 5;
                   end
               end
            4: if (s) m_state = 3;
               else if (md) begin m_state = 0; m_cnt = 0; end
            default: if (m_evq != 3'b000) m_state = 0;
        endcase
        m_evq  = b & ~m_prev;
        m_prev = b;
    endtask

    task automatic check_outputs();
        check("state", 32'(state), 32'(m_state));
        check("flags", {30'h0, running, done}, {30'h0, m_state == 3, m_state == 5});
        check("digits", dut_digits(), m_digits());
    endtask

    task automatic cyc();
        @(posedge clk);
        if (!reset) model_reset();
        else model_step();
        #1;
        check_outputs();
        @(negedge clk);
    endtask

    task automatic press(input logic [2:0] b, input int hold);
        {btn_start, btn_mode, btn_inc} = b;
        repeat (hold) cyc();
        {btn_start, btn_mode, btn_inc} = 3'b000;
        cyc();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        {btn_start, btn_mode, btn_inc} = 3'b000;
        model_reset();
        #1;
        check_outputs();
        @(negedge clk);
        reset = 1'b1;
        cyc();
    endtask

    initial begin
        int b, hold;
        model_reset();
        {btn_start, btn_mode, btn_inc} = 3'b111;
        #2 reset = 1'b0;
        #1;
        check("rst_state", 32'(state), 32'd0);
        check("rst_digits", dut_digits(), 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) cyc();
        check("held_no_event", 32'(state), 32'd0);
        {btn_start, btn_mode, btn_inc} = 3'b000;
        cyc();
        press(3'b010, 1);
        check("mode_to_setmin", 32'(state), 32'd1);

        // set 02:01 with one seconds wrap, then run
        do_reset();
        press(3'b010, 1);
        repeat (2) press(3'b001, 1);
        press(3'b010, 1);
        repeat (61) press(3'b001, 1);
        check("set_state", 32'(state), 32'd2);
        check("set_value", dut_digits(), 32'h0201);
        press(3'b100, 1);
        check("run_state", 32'(state), 32'd3);
        check("run_flag", 32'(running), 32'd1);
        repeat (3) cyc();
        check("no_early_dec", dut_digits(), 32'h0201);
        cyc();
        check("first_dec", dut_digits(), 32'h0200);
        repeat (4) cyc();
        check("second_dec", dut_digits(), 32'h0159);

        // 00:02 countdown to DONE
        do_reset();
        press(3'b010, 1);
        press(3'b010, 1);
        repeat (2) press(3'b001, 1);
        press(3'b100, 1);
        repeat (4) cyc();
        check("cd_0001", dut_digits(), 32'h0001);
        repeat (4) cyc();
        check("cd_0000", dut_digits(), 32'h0000);
        check("cd_done_state", 32'(state), 32'd5);
        check("cd_done_flag", {running, done}, 32'b01);
        press(3'b001, 1);
        check("done_to_idle", 32'(state), 32'd0);
        check("done_cleared", 32'(done), 32'd0);

        // pause two cycles into RUN, then resume from frozen prescaler
        do_reset();
        press(3'b010, 1);
        press(3'b001, 1);
        press(3'b100, 1);
        press(3'b100, 1);
        check("pause_state", 32'(state), 32'd4);
        repeat (20) cyc();
        check("pause_frozen_state", 32'(state), 32'd4);
        check("pause_frozen_value", dut_digits(), 32'h0100);
        press(3'b100, 1);
        check("resume_state", 32'(state), 32'd3);
        cyc();
        check("resume_hold", dut_digits(), 32'h0100);
        cyc();
        check("resume_dec", dut_digits(), 32'h0059);

        // coincident events
        do_reset();
        press(3'b010, 1);
        repeat (5) press(3'b001, 1);
        press(3'b111, 1);
        check("all3_state", 32'(state), 32'd3);
        check("all3_value", dut_digits(), 32'h0500);
        do_reset();
        press(3'b010, 1);
        press(3'b011, 1);
        check("modeinc_state", 32'(state), 32'd2);
        check("modeinc_value", dut_digits(), 32'h0000);

        do_reset();
        press(3'b100, 1);
        check("start_zero", 32'(state), 32'd0);

        // asynchronous reset in the middle of a run
        do_reset();
        press(3'b010, 1);
        repeat (3) press(3'b001, 1);
        press(3'b010, 1);
        repeat (17) press(3'b001, 1);
        press(3'b100, 1);
        check("pre_reset_value", dut_digits(), 32'h0317);
        reset = 1'b0;
        model_reset();
        #1;
        check("async_rst_state", 32'(state), 32'd0);
        check("async_rst_value", dut_digits(), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        cyc();

        repeat (250) begin
            if ($urandom_range(0, 39) == 0) do_reset();
            b = $urandom_range(1, 7);
            if (b == 5 || b == 6) b = 1;
            hold = $urandom_range(1, 3);
            press(3'(b), hold);
            repeat ($urandom_range(0, 12)) cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/timer_controller.md
# timer_controller

Central sequencer for the stopwatch/countdown timer: consumes the three debounced pushbutton levels, converts them to single-cycle events, and drives a mode state machine that sets, runs, pauses and expires an MM:SS countdown held in BCD. It sits between the per-button debouncers and the seven-segment display driver. It owns the 1 Hz prescaler, so the display path stays purely combinational.

## Interface
- TICK_DIV, 50000000: clk cycles per countdown second; legal range ≥ 2.
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- btn_mode  in  1  debounced mode button, active-high level.
- btn_inc  in  1  debounced increment button, active-high level.
- btn_start  in  1  debounced start/pause button, active-high level.
- min_tens  out  4  BCD minutes tens digit, 0–9.
- min_ones  out  4  BCD minutes ones digit, 0–9.
- sec_tens  out  4  BCD seconds tens digit, 0–5.
- sec_ones  out  4  BCD seconds ones digit, 0–9.
- state  out  3  current state: IDLE=0, SET_MIN=1, SET_SEC=2, RUN=3, PAUSE=4, DONE=5.
- running  out  1  high only in RUN.
- done  out  1  high only in DONE.

## Operation
- Edge detect: one previous-value register per button; event = btn & ~prev. The prev registers reset to 1, so a button held through reset produces no event.
- Priority when events coincide in one cycle: start > mode > inc. Lower-priority events in that cycle are discarded.
- IDLE:
  - mode → SET_MIN.
  - start → RUN if value ≠ 00:00; otherwise stay in IDLE.
  - inc ignored.
- SET_MIN:
  - inc → minutes +1 in BCD; 99 wraps to 00; seconds untouched.
  - mode → SET_SEC.
  - start → RUN if value ≠ 00:00.
- SET_SEC:
  - inc → seconds +1; 59 wraps to 00; minutes untouched.
  - mode → IDLE.
  - start → RUN if value ≠ 00:00.
- RUN:
  - On each prescaler tick, decrement MM:SS by one second with BCD borrow (x0 → (x−1)9; SS 00 → 59 with MM −1).
  - If the decrement yields 00:00 → DONE on the same edge.
  - start → PAUSE.
  - mode and inc ignored.
- PAUSE:
  - Value and prescaler count frozen.
  - start → RUN, prescaler resumes from its frozen count.
  - mode → IDLE with value retained and prescaler cleared.
  - inc ignored.
- DONE:
  - Value held at 00:00.
  - Any button event → IDLE.
- Prescaler: counts 0..TICK_DIV−1 only in RUN; tick asserts when count = TICK_DIV−1, then the count wraps to 0. The count clears on reset and on every transition into RUN from IDLE, SET_MIN or SET_SEC.
- A start event that coincides with a tick in RUN → PAUSE, and that tick's decrement is dropped.

## Timing
- Reset values (asynchronous, immediate on reset low):
  - state=IDLE, all digits=0, running=0, done=0.
  - prescaler=0, prev registers=1.
- Reset mid-RUN or mid-SET aborts immediately; the value is lost and becomes 00:00.
- Event latency:
  - btn sampled high at edge n after low at edge n−1 → event at edge n.
  - state/value change is visible after edge n+1, i.e. one register stage after the prev register.
  - Exactly one event per press, regardless of hold length.
- First decrement occurs TICK_DIV cycles after the edge at which state becomes RUN (fresh start). Each later decrement follows every TICK_DIV cycles.
- done/running are decoded registered state, with no extra cycle beyond state.
- Digit outputs are registered and never show an illegal BCD code (sec_tens ≤ 5, all others ≤ 9) in any cycle.

## Test plan
Bench uses TICK_DIV=4.
- Reset with all buttons held high, then release reset → state stays 0, no events, digits 00:00. Drop the buttons, re-press mode → state=1.
- From IDLE:
  - mode; inc ×2; mode; inc ×61 → state=2, display 02:01 (seconds wrapped 59 → 00 once).
  - Continue: start → state=3, running=1.
  - First decrement 4 cycles later → 02:00, then 01:59 4 cycles after that.
- Load 00:02, start → 00:01 after 4 cycles, 00:00 after 8 cycles with state=5, done=1 on the same edge.
  - Continue: press inc → state=0, done=0.
- In RUN, press start 2 cycles after entry → state=4, value frozen for 20 cycles.
  - Press start again → the next decrement occurs 2 cycles after resuming.
- Simultaneous edges:
  - start+mode+inc in SET_MIN with value 05:00 → RUN, minutes stay 05.
  - mode+inc in SET_MIN → SET_SEC, no increment.
- Start in IDLE with 00:00 → state stays 0. Assert reset mid-RUN at 03:17 → state=0, digits 00:00 immediately.
